// File: rtl/iso14443a_pcd_miller_tx_pkg.sv
// Shared types and constants for the ISO/IEC 14443-2 Type A PCD modified-Miller transmitter.
package iso14443a_pcd_miller_tx_pkg;

  localparam int BIT_PERIOD_TICKS = 128;
  localparam int HALF_BIT_TICKS   = 64;

  typedef enum logic [1:0] {MILLER_X, MILLER_Y, MILLER_Z} MillerSeq;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOC,
    ST_DATA,
    ST_EOC0,
    ST_EOCY,
    ST_GUARD
  } tx_state_e;

  // Sequence for a data bit: a 1 is always X; a 0 is Z after SOC or another 0, Y after a 1.
  function automatic MillerSeq data_seq(input logic data_bit, input logic prev_zero);
    if (data_bit) return MILLER_X;
    return prev_zero ? MILLER_Z : MILLER_Y;
  endfunction

endpackage

// File: rtl/iso14443a_pcd_miller_tx_if.sv
// Bit-stream handshake and modulator-side outputs of the PCD Miller transmitter.
interface iso14443a_pcd_miller_tx_if;
  logic in_bit;
  logic in_last;
  logic in_valid;
  logic in_ready;
  logic pause_n_out;
  logic busy;
  logic frame_done;
  logic underrun;

  modport master (
    output in_bit, in_last, in_valid,
    input  in_ready, pause_n_out, busy, frame_done, underrun
  );

  modport slave (
    input  in_bit, in_last, in_valid,
    output in_ready, pause_n_out, busy, frame_done, underrun
  );
endinterface

// File: rtl/iso14443a_miller_pause_gen.sv
// Maps the current Miller sequence and bit tick to the pause envelope (0 = carrier paused).
module iso14443a_miller_pause_gen
  import iso14443a_pcd_miller_tx_pkg::*;
#(
  parameter int PAUSE_TICKS = 32
) (
  input  MillerSeq   seq,
  input  logic [6:0] tick,
  output logic       pause_n
);

  localparam logic [6:0] PAUSE_LEN = 7'(PAUSE_TICKS);
  localparam logic [6:0] HALF      = 7'(HALF_BIT_TICKS);

  // Z pauses at the start of the bit, X at mid-bit, Y never.
  always_comb begin
    pause_n = 1'b1;
    case (seq)
      MILLER_Z: pause_n = !(tick < PAUSE_LEN);
      MILLER_X: pause_n = !((tick >= HALF) && ((tick - HALF) < PAUSE_LEN));
      default:  pause_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/iso14443a_pcd_miller_tx.sv
// ISO/IEC 14443-2 Type A PCD transmitter, 106 kbit/s: bit stream (LSB first) to modified-Miller
// pause envelope. Optional post-frame guard time is enabled by defining ISO14443A_PCD_GUARD_TIME_EN.
module iso14443a_pcd_miller_tx
  import iso14443a_pcd_miller_tx_pkg::*;
#(
  parameter int PAUSE_TICKS = 32,
  parameter int GUARD_TICKS = 1172
) (
  input  logic                        clk,
  input  logic                        rst,
  iso14443a_pcd_miller_tx_if.slave    bus
);

  localparam int              GW         = $clog2(GUARD_TICKS + 1);
  localparam logic [6:0]      TICK_LAST  = 7'(BIT_PERIOD_TICKS - 1);
  // GUARD lasts GUARD_TICKS-1 cycles; the single IDLE accept cycle completes the idle gap.
  localparam logic [GW-1:0]   GUARD_LOAD = GW'(GUARD_TICKS - 2);

  tx_state_e        state, state_nx;
  logic [6:0]       tick, tick_nx;
  MillerSeq         seq, seq_nx;
  logic             prev_zero, prev_zero_nx;
  logic             data_bit, data_bit_nx;
  logic             data_last, data_last_nx;
  logic [GW-1:0]    guard_cnt, guard_cnt_nx;
  logic             in_ready_q, in_ready_nx;
  logic             pause_n_q, pause_n_nx;
  logic             busy_q, busy_nx;
  logic             frame_done_q, frame_done_nx;
  logic             underrun_q, underrun_nx;
  logic             accept, wrap;

  assign accept = bus.in_valid && in_ready_q;
  assign wrap   = (tick == TICK_LAST);

  iso14443a_miller_pause_gen #(.PAUSE_TICKS(PAUSE_TICKS)) u_pause_gen (
    .seq     (seq_nx),
    .tick    (tick_nx),
    .pause_n (pause_n_nx)
  );

  // Next-state, sequence selection and registered-output values for the coming cycle.
  always_comb begin
    state_nx     = state;
    tick_nx      = 7'd0;
    seq_nx       = seq;
    prev_zero_nx = prev_zero;
    data_bit_nx  = data_bit;
    data_last_nx = data_last;
    guard_cnt_nx = guard_cnt;
    underrun_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        seq_nx = MILLER_Y;
        if (accept) begin
          data_bit_nx  = bus.in_bit;
          data_last_nx = bus.in_last;
          prev_zero_nx = 1'b1;
          state_nx     = ST_SOC;
          seq_nx       = MILLER_Z;
        end
      end
      ST_SOC: begin
        tick_nx = tick + 7'd1;
        if (wrap) begin
          state_nx     = ST_DATA;
          seq_nx       = data_seq(data_bit, prev_zero);
          prev_zero_nx = !data_bit;
        end
      end
      ST_DATA: begin
        tick_nx = tick + 7'd1;
        if (wrap) begin
          if (accept) begin
            data_bit_nx  = bus.in_bit;
            data_last_nx = bus.in_last;
            seq_nx       = data_seq(bus.in_bit, prev_zero);
            prev_zero_nx = !bus.in_bit;
          end else begin
            // Either the frame ended normally or the source starved us; both close with EOC.
            underrun_nx = !data_last;
            state_nx    = ST_EOC0;
            seq_nx      = data_seq(1'b0, prev_zero);
          end
        end
      end
      ST_EOC0: begin
        tick_nx = tick + 7'd1;
        if (wrap) begin
          state_nx = ST_EOCY;
          seq_nx   = MILLER_Y;
        end
      end
      ST_EOCY: begin
        tick_nx = tick + 7'd1;
        if (wrap) begin
          seq_nx = MILLER_Y;
`ifdef ISO14443A_PCD_GUARD_TIME_EN
          state_nx     = ST_GUARD;
          guard_cnt_nx = GUARD_LOAD;
`else
          state_nx = ST_IDLE;
`endif
        end
      end
      ST_GUARD: begin
        seq_nx = MILLER_Y;
        if (guard_cnt == '0) state_nx = ST_IDLE;
        else guard_cnt_nx = guard_cnt - GW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
    in_ready_nx   = (state_nx == ST_IDLE) ||
                    ((state_nx == ST_DATA) && (tick_nx == TICK_LAST) && !data_last_nx);
    busy_nx       = (state_nx != ST_IDLE);
    frame_done_nx = (state_nx == ST_EOCY) && (tick_nx == TICK_LAST);
  end

  // Control state and registered outputs; reset forces carrier on immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      tick         <= 7'd0;
      seq          <= MILLER_Y;
      prev_zero    <= 1'b0;
      guard_cnt    <= '0;
      in_ready_q   <= 1'b0;
      pause_n_q    <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state        <= state_nx;
      tick         <= tick_nx;
      seq          <= seq_nx;
      prev_zero    <= prev_zero_nx;
      guard_cnt    <= guard_cnt_nx;
      in_ready_q   <= in_ready_nx;
      pause_n_q    <= pause_n_nx;
      busy_q       <= busy_nx;
      frame_done_q <= frame_done_nx;
      underrun_q   <= underrun_nx;
    end
  end

  // Stored bit and last flag; only meaningful while a frame is active, so no reset.
  always_ff @(posedge clk) begin
    data_bit  <= data_bit_nx;
    data_last <= data_last_nx;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.pause_n_out = pause_n_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_iso14443a_pcd_miller_tx.sv
// Self-checking bench for iso14443a_pcd_miller_tx against a sequence-level Miller model.
module tb_iso14443a_pcd_miller_tx;

  localparam int P = 32;
  localparam int G = 1172;
`ifdef ISO14443A_PCD_GUARD_TIME_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iso14443a_pcd_miller_tx_if bus();

  iso14443a_pcd_miller_tx #(.PAUSE_TICKS(P), .GUARD_TICKS(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit env_q[$];
  int fd_idx;
  int ur_idx;
  int ur_count;

  // Expected sequence string from the encoding rules: SOC, data bits, EOC logic 0, then Y.
  function automatic string model_seqs(input bit bits[$]);
    string s;
    bit pz;
    s  = "Z";
    pz = 1'b1;
    foreach (bits[i]) begin
      if (bits[i]) s = {s, "X"};
      else if (pz) s = {s, "Z"};
      else s = {s, "Y"};
      pz = !bits[i];
    end
    if (pz) s = {s, "Z"};
    else s = {s, "Y"};
    s = {s, "Y"};
    return s;
  endfunction

  // Number of ticks where the recorded envelope differs from the ideal envelope of a sequence string.
  function automatic int model_mismatches(input string s);
    int n;
    bit exp_low;
    int idx;
    n = 0;
    if (env_q.size() != 128 * s.len()) n++;
    for (int k = 0; k < s.len(); k++) begin
      for (int t = 0; t < 128; t++) begin
        exp_low = ((s[k] == "Z") && (t < P)) || ((s[k] == "X") && (t >= 64) && (t < 64 + P));
        idx = k * 128 + t;
        if (idx >= env_q.size()) n++;
        else if (env_q[idx] != !exp_low) n++;
      end
    end
    return n;
  endfunction

  function automatic string observed_seqs();
    string s;
    s = "";
    for (int k = 0; k < env_q.size() / 128; k++) begin
      if (!env_q[k*128]) s = {s, "Z"};
      else if (!env_q[k*128+64]) s = {s, "X"};
      else s = {s, "Y"};
    end
    return s;
  endfunction

  function automatic int observed_pauses();
    int n;
    bit prev;
    n = 0;
    prev = 1'b1;
    foreach (env_q[i]) begin
      if (prev && !env_q[i]) n++;
      prev = env_q[i];
    end
    return n;
  endfunction

  // Streams bits (stopping at drop_at if >= 0) and records pause_n_out from SOC tick 0 to frame_done.
  task automatic run_frame(input bit bits[$], input int drop_at);
    int idx;
    bit acc, started, done;
    env_q.delete();
    fd_idx = -1; ur_idx = -1; ur_count = 0;
    started = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    idx = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = bits[0];
    bus.in_last  = (bits.size() == 1);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (started && bus.busy) begin
        env_q.push_back(bus.pause_n_out);
        if (bus.underrun) begin ur_count++; ur_idx = env_q.size() - 1; end
        if (bus.frame_done) begin fd_idx = env_q.size() - 1; done = 1'b1; end
      end
      if (done) break;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        started = 1'b1;
        idx++;
        if (idx < bits.size() && idx != drop_at) begin
          bus.in_bit  = bits[idx];
          bus.in_last = (idx == bits.size() - 1);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.pause_n_out !== 1'b1) begin bad++; $display("FAIL reset_pause_n: got %b expected 1", bus.pause_n_out); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b expected 0", bus.underrun); end
    // Valid presented on the very edge reset is released must be ignored.
    rst = 1'b0; bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.in_last = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b expected 0", bus.busy); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL release_no_frame: got %b expected 0", bus.busy); end
  endtask

  task automatic test_patterns();
    byte unsigned vals[3] = '{8'h26, 8'hFF, 8'h00};
    int           nb[3]   = '{7, 8, 8};
    string        seqs[3] = '{"ZZXXYZXYZY", "ZXXXXXXXXYY", "ZZZZZZZZZZY"};
    int           np[3]   = '{7, 9, 10};
    bit bits[$];
    byte unsigned v;
    string obs;
    int mm, pc;
    for (int p = 0; p < 3; p++) begin
      bits.delete();
      v = vals[p];
      for (int i = 0; i < nb[p]; i++) bits.push_back(v[i]);
      run_frame(bits, -1);
      obs = observed_seqs();
      pc  = observed_pauses();
      mm  = model_mismatches(model_seqs(bits));
      total++; if (obs != seqs[p]) begin bad++; $display("FAIL pattern%0d_seqs: got %s expected %s", p, obs, seqs[p]); end
      total++; if (pc != np[p]) begin bad++; $display("FAIL pattern%0d_pauses: got %0d expected %0d", p, pc, np[p]); end
      total++; if (mm != 0) begin bad++; $display("FAIL pattern%0d_envelope: got %0d bad ticks expected 0", p, mm); end
      total++; if (fd_idx != 128 * seqs[p].len() - 1) begin bad++; $display("FAIL pattern%0d_frame_done: got tick %0d expected %0d", p, fd_idx, 128 * seqs[p].len() - 1); end
      total++; if (ur_count != 0) begin bad++; $display("FAIL pattern%0d_underrun: got %0d expected 0", p, ur_count); end
    end
  endtask

  task automatic test_underrun();
    bit bits[$];
    bit sent[$];
    int mm;
    for (int i = 0; i < 8; i++) bits.push_back(1'($urandom));
    for (int i = 0; i < 3; i++) sent.push_back(bits[i]);
    run_frame(bits, 3);
    mm = model_mismatches(model_seqs(sent));
    total++; if (ur_count != 1) begin bad++; $display("FAIL underrun_count: got %0d expected 1", ur_count); end
    total++; if (ur_idx != 4 * 128) begin bad++; $display("FAIL underrun_tick: got %0d expected %0d", ur_idx, 4 * 128); end
    total++; if (fd_idx - ur_idx != 255) begin bad++; $display("FAIL underrun_to_done: got %0d expected 255", fd_idx - ur_idx); end
    total++; if (mm != 0) begin bad++; $display("FAIL underrun_envelope: got %0d bad ticks expected 0", mm); end
  endtask

  task automatic test_random();
    bit bits[$];
    bit sent[$];
    int n, drop, mm;
    string s;
    for (int it = 0; it < 6; it++) begin
      bits.delete(); sent.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) bits.push_back(1'($urandom));
      drop = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
      for (int i = 0; i < ((drop < 0) ? n : drop); i++) sent.push_back(bits[i]);
      run_frame(bits, drop);
      s  = model_seqs(sent);
      mm = model_mismatches(s);
      total++; if (mm != 0) begin bad++; $display("FAIL random%0d_envelope: got %0d bad ticks expected 0 (n=%0d drop=%0d)", it, mm, n, drop); end
      total++; if (fd_idx != 128 * s.len() - 1) begin bad++; $display("FAIL random%0d_frame_done: got %0d expected %0d", it, fd_idx, 128 * s.len() - 1); end
      total++; if (ur_count != ((drop < 0) ? 0 : 1)) begin bad++; $display("FAIL random%0d_underrun: got %0d expected %0d", it, ur_count, (drop < 0) ? 0 : 1); end
    end
  endtask

  task automatic test_rst_mid_pause();
    int i;
    bit bits[$];
    int mm;
    string s;
    for (int c = 0; c < 2000 && bus.busy; c++) @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.in_last = 1'b1;
    i = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.busy) begin bus.in_valid = 1'b0; i++; end
      if (i == 128 + 70) break;
    end
    total++; if (bus.pause_n_out !== 1'b0) begin bad++; $display("FAIL midpause_low: got %b expected 0 (i=%0d)", bus.pause_n_out, i); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.pause_n_out !== 1'b1) begin bad++; $display("FAIL midpause_rst_pause_n: got %b expected 1", bus.pause_n_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midpause_rst_busy: got %b expected 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midpause_rst_in_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midpause_release_in_ready: got %b expected 1", bus.in_ready); end
    for (int k = 0; k < 5; k++) bits.push_back(1'($urandom));
    run_frame(bits, -1);
    s  = model_seqs(bits);
    mm = model_mismatches(s);
    total++; if (mm != 0) begin bad++; $display("FAIL midpause_after_envelope: got %0d bad ticks expected 0", mm); end
    total++; if (fd_idx != 128 * s.len() - 1) begin bad++; $display("FAIL midpause_after_done: got %0d expected %0d", fd_idx, 128 * s.len() - 1); end
  endtask

  task automatic test_back_to_back();
    int gap;
    int exp_gap;
    bit seen;
    exp_gap = GUARD_EN ? G + 1 : 2;
    for (int c = 0; c < 2000 && bus.busy; c++) @(negedge clk);
    @(posedge clk); #1;
    bus.in_bit = 1'($urandom); bus.in_last = 1'b1; bus.in_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.frame_done) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL b2b_first_done: got 0 expected 1 within 2000 cycles"); end
    @(negedge clk);
    total++; if (bus.busy !== GUARD_EN) begin bad++; $display("FAIL b2b_gap_busy: got %b expected %b", bus.busy, GUARD_EN); end
    gap = 1;
    for (int c = 0; c < G + 100; c++) begin
      if (bus.pause_n_out == 1'b0) break;
      @(negedge clk);
      gap++;
    end
    total++; if (gap != exp_gap) begin bad++; $display("FAIL b2b_soc_gap: got %0d expected %0d", gap, exp_gap); end
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.frame_done) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL b2b_second_done: got 0 expected 1 within 2000 cycles"); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;
    test_reset();
    test_rst_mid_pause();
    test_patterns();
    test_underrun();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
